pcihellocore_buttonin: RTL and testbench

Avalon-MM memory-mapped input port for the pcihellocore system: the read-side counterpart of the output PIOs that drive the hex displays. It samples an external WIDTH-bit input bus (push-buttons/switches), synchronises and debounces it, and latches per-bit edge events. It raises a maskable level interrupt to the PCIe host. The host reads the debounced input state and edge flags, and clears the flags, through the same Avalon s1 slave fabric used by the output ports.

---
 rtl/pcihellocore_buttonin.sv | 97 +++++++++
 tb/tb_pcihellocore_buttonin.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcihellocore_buttonin.sv
// Avalon-MM input port: synchronised, debounced WIDTH-bit input with per-bit edge capture
// and a maskable level interrupt.
module pcihellocore_buttonin #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1_q, s2_q, p_q, deb_q, deb_d, deb_dly_q;
  logic [WIDTH-1:0] edge_q, edge_d, mask_q;
  logic [WIDTH-1:0] ev, clr, diff;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tick, wr_en, mask_we;

  assign tick    = (cnt_q == CntMax);
  assign cnt_d   = tick ? '0 : cnt_q + CntW'(1);
  assign wr_en   = chipselect & ~write_n;
  assign mask_we = wr_en && (address == 2'd2);
  assign clr     = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;

  // A bit only follows s2 when the previous tick saw the same level.
  assign diff  = s2_q ^ p_q;
  assign deb_d = (~diff & s2_q) | (diff & deb_q);

  always_comb begin
    ev = '0;
    if (EDGE_TYPE == 0) begin
      ev = deb_q & ~deb_dly_q;
    end else if (EDGE_TYPE == 1) begin
      ev = ~deb_q & deb_dly_q;
    end else begin
      ev = deb_q ^ deb_dly_q;
    end
  end

  // Event is OR-ed in after the clear so a same-cycle event wins.
  assign edge_d = (edge_q & ~clr) | ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      p_q       <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      edge_q    <= '0;
      mask_q    <= '0;
      cnt_q     <= '0;
    end else begin
      s1_q      <= in_port;
      s2_q      <= s1_q;
      cnt_q     <= cnt_d;
      deb_dly_q <= deb_q;
      edge_q    <= edge_d;
      if (tick) begin
        p_q   <= s2_q;
        deb_q <= deb_d;
      end
      if (mask_we) begin
        mask_q <= writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = deb_q;
      2'd2:    readdata[WIDTH-1:0] = mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

  generate
    if (WIDTH < 32) begin : g_unused
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_pcihellocore_buttonin.sv
// Bench for pcihellocore_buttonin: rising, falling and any-edge instances share one bus and input.
module tb_pcihellocore_buttonin;

  localparam int unsigned W  = 4;
  localparam int unsigned DC = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [W-1:0]  in_port = '0;
  logic [31:0]   rdata [3];
  logic          irqv  [3];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic        cs;
    logic        wn;
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  raddr;
    logic [31:0] rexp;
    logic        iexp;
  } bus_vec_t;

  bus_vec_t vecs [14];

  always #5 clk = ~clk;

  pcihellocore_buttonin #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[0]), .irq(irqv[0])
  );
  pcihellocore_buttonin #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[1]), .irq(irqv[1])
  );
  pcihellocore_buttonin #(.WIDTH(W), .DEBOUNCE_CYCLES(DC), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(rdata[2]), .irq(irqv[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input int d, input logic [1:0] a, output logic [31:0] v);
    address = a;
    #1;
    v = rdata[d];
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  // Returns the number of edges until (reg & m) == val, or -1 on timeout.
  task automatic wait_reg(input int d, input logic [1:0] a, input logic [31:0] m,
                          input logic [31:0] val, input int max, output int n);
    logic [31:0] v;
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      rd(d, a, v);
      if ((v & m) == val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    in_port    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int n;

    vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 2'd0, 32'h5, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 2'd1, 32'h0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 2'd2, 32'h0,         2'd2, 32'h0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 2'd2, 32'hFFFF_FFFF, 2'd2, 32'hF, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 2'd0, 32'h0,         2'd3, 32'h5, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 2'd3, 32'h1,         2'd3, 32'h4, 1'b1};
    vecs[6]  = '{1'b1, 1'b0, 2'd2, 32'h9,         2'd2, 32'h9, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 2'd3, 32'h4, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'd3, 32'hFFFF_FFF0, 2'd3, 32'h4, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 2'd2, 32'h0,         2'd2, 32'h9, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'd2, 32'h0,         2'd2, 32'h9, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 2'd2, 32'h4,         2'd2, 32'h4, 1'b1};
    vecs[12] = '{1'b1, 1'b0, 2'd3, 32'h4,         2'd3, 32'h0, 1'b0};
    vecs[13] = '{1'b0, 1'b1, 2'd0, 32'h0,         2'd0, 32'h5, 1'b0};

    // Reset with inputs high
    in_port = 4'hF;
    #2;
    rd(0, 2'd0, v); chk("rst_data", v, 32'h0);
    rd(0, 2'd3, v); chk("rst_edgecap", v, 32'h0);
    rd(0, 2'd2, v); chk("rst_mask", v, 32'h0);
    chk("rst_irq", {31'b0, irqv[0] | irqv[1] | irqv[2]}, 32'h0);
    step(2);
    reset_n = 1'b1;
    wait_reg(0, 2'd0, 32'hF, 32'hF, 2 + 2 * DC + 2, n);
    chk("rst_latency", n, 32'd8);
    rd(0, 2'd3, v); chk("rst_edge_not_yet", v, 32'h0);
    step(1);
    rd(0, 2'd3, v); chk("rst_edge_rise", v, 32'hF);
    rd(1, 2'd3, v); chk("rst_edge_fall", v, 32'h0);
    rd(2, 2'd3, v); chk("rst_edge_any", v, 32'hF);

    // Debounce: short pulse rejected, held level accepted
    do_reset();
    in_port = 4'h1;
    step(3);
    in_port = 4'h0;
    step(12);
    rd(0, 2'd0, v); chk("pulse_data", v, 32'h0);
    rd(0, 2'd3, v); chk("pulse_edgecap", v, 32'h0);
    in_port = 4'h1;
    wait_reg(0, 2'd0, 32'h1, 32'h1, 12, n);
    chk("level_latency_ok", {31'b0, (n >= 7 && n <= 10)}, 32'h1);
    rd(0, 2'd3, v); chk("level_edge_not_yet", v, 32'h0);
    step(1);
    rd(0, 2'd3, v); chk("level_edge", v, 32'h1);
    chk("level_irq_unmasked", {31'b0, irqv[0]}, 32'h0);

    // Interrupt mask
    do_reset();
    wr(2'd2, 32'h2);
    in_port = 4'h1;
    wait_reg(0, 2'd3, 32'h1, 32'h1, 14, n);
    chk("mask_b0_timeout", {31'b0, n > 0}, 32'h1);
    rd(0, 2'd3, v); chk("mask_b0_edgecap", v, 32'h1);
    chk("mask_b0_irq", {31'b0, irqv[0]}, 32'h0);
    in_port = 4'h3;
    n = -1;
    for (int i = 1; i <= 14; i++) begin
      step(1);
      rd(0, 2'd3, v);
      if (v[1]) begin
        n = i;
        chk("mask_b1_irq", {31'b0, irqv[0]}, 32'h1);
        break;
      end
      chk("mask_b1_irq_early", {31'b0, irqv[0]}, 32'h0);
    end
    chk("mask_b1_timeout", {31'b0, n > 0}, 32'h1);
    rd(0, 2'd3, v); chk("mask_b1_edgecap", v, 32'h3);
    wr(2'd3, 32'h2);
    chk("clr_irq", {31'b0, irqv[0]}, 32'h0);
    rd(0, 2'd3, v); chk("clr_edgecap", v, 32'h1);
    wr(2'd2, 32'h1);
    chk("mask_new_irq", {31'b0, irqv[0]}, 32'h1);
    wr(2'd2, 32'h0);
    chk("mask_off_irq", {31'b0, irqv[0]}, 32'h0);

    // Clear colliding with an event on the same bit
    do_reset();
    in_port = 4'h4;
    wait_reg(0, 2'd0, 32'h4, 32'h4, 12, n);
    chk("coll_timeout", {31'b0, n > 0}, 32'h1);
    rd(0, 2'd3, v); chk("coll_pre", v, 32'h0);
    wr(2'd3, 32'h4);
    rd(0, 2'd3, v); chk("coll_event_wins", v, 32'h4);
    wr(2'd3, 32'h4);
    rd(0, 2'd3, v); chk("coll_later_clear", v, 32'h0);

    // Falling and any-edge modes
    do_reset();
    in_port = 4'h8;
    wait_reg(1, 2'd0, 32'h8, 32'h8, 12, n);
    chk("fall_press_timeout", {31'b0, n > 0}, 32'h1);
    step(2);
    rd(1, 2'd3, v); chk("fall_press", v, 32'h0);
    rd(2, 2'd3, v); chk("any_press", v, 32'h8);
    rd(0, 2'd3, v); chk("rise_press", v, 32'h8);
    wr(2'd3, 32'h8);
    rd(2, 2'd3, v); chk("any_clr", v, 32'h0);
    in_port = 4'h0;
    wait_reg(1, 2'd0, 32'h8, 32'h0, 12, n);
    chk("fall_rel_timeout", {31'b0, n > 0}, 32'h1);
    step(1);
    rd(1, 2'd3, v); chk("fall_release", v, 32'h8);
    rd(2, 2'd3, v); chk("any_release", v, 32'h8);
    rd(0, 2'd3, v); chk("rise_release", v, 32'h0);

    // Bus map
    do_reset();
    in_port = 4'h5;
    step(12);
    rd(0, 2'd0, v); chk("bus_setup_data", v, 32'h5);
    for (int i = 0; i < 14; i++) begin
      address    = vecs[i].waddr;
      writedata  = vecs[i].wdata;
      chipselect = vecs[i].cs;
      write_n    = vecs[i].wn;
      step(1);
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = '0;
      rd(0, vecs[i].raddr, v);
      chk($sformatf("bus%0d_rd", i), v, vecs[i].rexp);
      chk($sformatf("bus%0d_irq", i), {31'b0, irqv[0]}, {31'b0, vecs[i].iexp});
    end

    // Reset mid-operation
    do_reset();
    in_port = 4'hF;
    step(12);
    wr(2'd2, 32'hF);
    rd(0, 2'd3, v); chk("mid_pre_edgecap", v, 32'hF);
    chk("mid_pre_irq", {31'b0, irqv[0]}, 32'h1);
    in_port = 4'h0;
    step(3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_irq", {31'b0, irqv[0] | irqv[1] | irqv[2]}, 32'h0);
    rd(0, 2'd0, v); chk("mid_data", v, 32'h0);
    rd(0, 2'd2, v); chk("mid_mask", v, 32'h0);
    rd(0, 2'd3, v); chk("mid_edgecap", v, 32'h0);
    step(2);
    reset_n = 1'b1;
    step(12);
    rd(0, 2'd0, v); chk("mid_after_data", v, 32'h0);
    rd(2, 2'd3, v); chk("mid_after_edgecap", v, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
